// File: rtl/spi_initiator_ctrl.sv
// SPI initiator: valid/ready words shifted out on mosi while miso is captured; received word strobed on rx_valid.
// Latency accept->rx_valid = (2*DAT_WIDTH+1)*(cfg_div+1)+1 clk; tx_ready only in IDLE, rx_valid has no backpressure.
module spi_initiator_ctrl #(
   parameter int DAT_WIDTH = 8,
   parameter int NUM_CS    = 4,
   parameter int DIV_WIDTH = 8
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       cfg_cpol,
   input  logic                                       cfg_cpha,
   input  logic                                       cfg_lsb,
   input  logic [DIV_WIDTH-1:0]                       cfg_div,
   input  logic                                       tx_valid,
   output logic                                       tx_ready,
   input  logic [DAT_WIDTH-1:0]                       tx_data,
   input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] tx_cs,
   output logic                                       rx_valid,
   output logic [DAT_WIDTH-1:0]                       rx_data,
   output logic                                       busy,
   output logic                                       cs_err,
   output logic                                       sck,
   output logic [NUM_CS-1:0]                          csn,
   output logic                                       mosi,
   input  logic                                       miso
);
   localparam int            EW        = $clog2(2 * DAT_WIDTH);
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DAT_WIDTH - 1);
   localparam logic [31:0]   NCS       = NUM_CS;

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t                 r_state;
   logic                   r_cpol, r_cpha, r_lsb;
   logic [DIV_WIDTH-1:0]   r_div, r_cnt;
   logic [EW-1:0]          r_edge;
   logic [DAT_WIDTH-1:0]   r_tx, r_rx;
   logic                   r_hold_ph, r_hold_first;
   logic                   r_tx_ready, r_rx_valid, r_busy, r_cs_err, r_sck, r_mosi;
   logic [DAT_WIDTH-1:0]   r_rx_data;
   logic [NUM_CS-1:0]      r_csn;

   logic                   w_accept, w_cs_bad, w_tick, w_sample, w_tx_bit, w_in_bit;
   logic [DAT_WIDTH-1:0]   w_tx_nxt, w_rx_nxt, w_in_nxt;
   logic [NUM_CS-1:0]      w_csn_sel;

   assign w_accept = tx_valid && r_tx_ready;
   assign w_cs_bad = (32'(tx_cs) >= NCS);
   assign w_tick   = (r_cnt == '0);
   // Even edge indices are leading edges; CPHA selects which of the pair samples.
   assign w_sample = ~r_edge[0] ^ r_cpha;
   assign w_tx_bit = r_lsb ? r_tx[0] : r_tx[DAT_WIDTH-1];
   assign w_tx_nxt = r_lsb ? {1'b0, r_tx[DAT_WIDTH-1:1]} : {r_tx[DAT_WIDTH-2:0], 1'b0};
   assign w_rx_nxt = r_lsb ? {miso, r_rx[DAT_WIDTH-1:1]} : {r_rx[DAT_WIDTH-2:0], miso};
   assign w_in_bit = cfg_lsb ? tx_data[0] : tx_data[DAT_WIDTH-1];
   assign w_in_nxt = cfg_lsb ? {1'b0, tx_data[DAT_WIDTH-1:1]} : {tx_data[DAT_WIDTH-2:0], 1'b0};

   always_comb begin
      w_csn_sel = '1;
      for (int i = 0; i < NUM_CS; i++)
         if (32'(tx_cs) == 32'(i)) w_csn_sel[i] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cpol       <= 1'b1;
         r_cpha       <= 1'b0;
         r_lsb        <= 1'b0;
         r_div        <= '0;
         r_cnt        <= '0;
         r_edge       <= '0;
         r_tx         <= '0;
         r_rx         <= '0;
         r_hold_ph    <= 1'b0;
         r_hold_first <= 1'b0;
         r_tx_ready   <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_rx_data    <= '0;
         r_busy       <= 1'b0;
         r_cs_err     <= 1'b0;
         r_sck        <= 1'b1;
         r_csn        <= '1;
         r_mosi       <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_cs_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               r_sck <= cfg_cpol;
               if (w_accept) begin
                  r_cpol     <= cfg_cpol;
                  r_cpha     <= cfg_cpha;
                  r_lsb      <= cfg_lsb;
                  r_div      <= cfg_div;
                  r_cnt      <= cfg_div;
                  r_edge     <= '0;
                  r_rx       <= '0;
                  r_tx_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_cs_err   <= w_cs_bad;
                  r_csn      <= w_cs_bad ? '1 : w_csn_sel;
                  r_state    <= SETUP;
                  // CPHA=0 presents the first bit before the first SCK edge.
                  if (!cfg_cpha) begin
                     r_mosi <= w_in_bit;
                     r_tx   <= w_in_nxt;
                  end else begin
                     r_tx   <= tx_data;
                  end
               end else begin
                  r_tx_ready <= 1'b1;
               end
            end
            SETUP: begin
               if (w_tick) begin
                  r_cnt   <= r_div;
                  r_state <= XFER;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            XFER: begin
               if (w_tick) begin
                  r_cnt <= r_div;
                  r_sck <= ~r_sck;
                  if (w_sample) begin
                     r_rx <= w_rx_nxt;
                  end else begin
                     r_mosi <= w_tx_bit;
                     r_tx   <= w_tx_nxt;
                  end
                  if (r_edge == LAST_EDGE) begin
                     r_state      <= HOLD;
                     r_hold_first <= 1'b1;
                     r_hold_ph    <= 1'b0;
                  end else begin
                     r_edge <= r_edge + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            HOLD: begin
               r_sck <= r_cpol;
               if (r_hold_first) begin
                  r_hold_first <= 1'b0;
                  r_rx_valid   <= 1'b1;
                  r_rx_data    <= r_rx;
               end
               // First half-period keeps csn asserted, second runs with csn released.
               if (w_tick) begin
                  r_cnt <= r_div;
                  if (!r_hold_ph) begin
                     r_hold_ph <= 1'b1;
                     r_csn     <= '1;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tx_ready = r_tx_ready;
   assign rx_valid = r_rx_valid;
   assign rx_data  = r_rx_data;
   assign busy     = r_busy;
   assign cs_err   = r_cs_err;
   assign sck      = r_sck;
   assign csn      = r_csn;
   assign mosi     = r_mosi;

endmodule

// File: tb/tb_spi_initiator_ctrl.sv
// Bench for spi_initiator_ctrl: 8-bit/4-CS instance (A) and 16-bit/5-CS instance (B) with rx scoreboards.
module tb_spi_initiator_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       cfg_cpol, cfg_cpha, cfg_lsb;
   logic [7:0] cfg_div;

   logic        tx_valid_a, tx_ready_a, rx_valid_a, busy_a, cs_err_a, sck_a, mosi_a, miso_a;
   logic [7:0]  tx_data_a, rx_data_a;
   logic [1:0]  tx_cs_a;
   logic [3:0]  csn_a;
   logic        tx_valid_b, tx_ready_b, rx_valid_b, busy_b, cs_err_b, sck_b, mosi_b, miso_b;
   logic [15:0] tx_data_b, rx_data_b;
   logic [2:0]  tx_cs_b;
   logic [4:0]  csn_b;

   logic       use_tgt = 1'b0;
   logic [7:0] tgt_word = 8'h00;
   logic [2:0] tgt_idx = 3'd0;
   assign miso_a = use_tgt ? tgt_word[tgt_idx] : mosi_a;
   assign miso_b = mosi_b;

   spi_initiator_ctrl #(.DAT_WIDTH(8), .NUM_CS(4), .DIV_WIDTH(8)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb(cfg_lsb),
      .cfg_div(cfg_div), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
      .tx_cs(tx_cs_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a), .busy(busy_a),
      .cs_err(cs_err_a), .sck(sck_a), .csn(csn_a), .mosi(mosi_a), .miso(miso_a));

   spi_initiator_ctrl #(.DAT_WIDTH(16), .NUM_CS(5), .DIV_WIDTH(8)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb(cfg_lsb),
      .cfg_div(cfg_div), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
      .tx_cs(tx_cs_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b), .busy(busy_b),
      .cs_err(cs_err_b), .sck(sck_b), .csn(csn_b), .mosi(mosi_b), .miso(miso_b));

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboards: expected word, accept cycle and expected latency per accepted request.
   logic [7:0]  exp_q_a[$];
   logic [15:0] exp_q_b[$];
   int t_q_a[$], lat_q_a[$], t_q_b[$], lat_q_b[$];

   logic prev_sck_a = 1'b1, prev_busy_a = 1'b0, prev_sck_b = 1'b1, seen_fall_a = 1'b0, csn_low_b = 1'b0;
   logic sck_at_rx_b = 1'b1;
   logic [7:0] cap_a = 8'h00;
   logic [3:0] mid_csn_a = 4'hF;
   int tog_a = 0, rise_a = 0, per_a = 0, last_rise_a = 0, t_acc_a = -1, fall_a = 0;
   int n_rx_a = 0, acc_a = 0, cserr_cnt_a = 0;
   int tog_b = 0, per_b = 0, last_rise_b = 0, n_rx_b = 0, cserr_cnt_b = 0;

   always @(negedge clk) if (rst_n) begin
      if (tx_valid_a && tx_ready_a) begin
         exp_q_a.push_back(use_tgt ? tgt_word : tx_data_a);
         t_q_a.push_back(cyc + 1);
         lat_q_a.push_back(17 * (int'(cfg_div) + 1) + 1);
         if (seen_fall_a) chk("idle_gap_a", 32'((cyc - fall_a) >= 1), 1);
         tog_a = 0; rise_a = 0; cap_a = 8'h00; t_acc_a = cyc + 1; acc_a++;
      end
      if (cyc == t_acc_a) mid_csn_a = csn_a;
      if (sck_a != prev_sck_a) begin
         tog_a++;
         if (sck_a) begin
            if (rise_a < 8) cap_a[rise_a] = mosi_a;
            rise_a++;
            per_a = cyc - last_rise_a;
            last_rise_a = cyc;
         end else if (csn_a != 4'hF) begin
            tgt_idx = tgt_idx + 3'd1;
         end
      end
      if (csn_a == 4'hF) tgt_idx = 3'd0;
      prev_sck_a = sck_a;
      if (cs_err_a) cserr_cnt_a++;
      if (prev_busy_a && !busy_a) begin fall_a = cyc; seen_fall_a = 1'b1; end
      prev_busy_a = busy_a;
      if (rx_valid_a) begin
         n_rx_a++;
         if (exp_q_a.size() == 0) chk("rx_a_unexpected", 1, 0);
         else begin
            chk("rx_a_data", rx_data_a, exp_q_a.pop_front());
            chk("rx_a_latency", cyc - t_q_a.pop_front(), lat_q_a.pop_front());
         end
      end
   end

   always @(negedge clk) if (rst_n) begin
      if (tx_valid_b && tx_ready_b) begin
         exp_q_b.push_back(tx_data_b);
         t_q_b.push_back(cyc + 1);
         lat_q_b.push_back(33 * (int'(cfg_div) + 1) + 1);
         tog_b = 0;
      end
      if (sck_b != prev_sck_b) begin
         tog_b++;
         if (sck_b) begin per_b = cyc - last_rise_b; last_rise_b = cyc; end
      end
      prev_sck_b = sck_b;
      if (cs_err_b) cserr_cnt_b++;
      if (csn_b != 5'h1F) csn_low_b = 1'b1;
      if (rx_valid_b) begin
         n_rx_b++;
         sck_at_rx_b = sck_b;
         if (exp_q_b.size() == 0) chk("rx_b_unexpected", 1, 0);
         else begin
            chk("rx_b_data", rx_data_b, exp_q_b.pop_front());
            chk("rx_b_latency", cyc - t_q_b.pop_front(), lat_q_b.pop_front());
         end
      end
   end

   task automatic set_cfg(input logic cpol, input logic cpha, input logic lsb, input logic [7:0] div);
      cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb = lsb; cfg_div = div;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [7:0] d, input logic [1:0] cs);
      int k = 0;
      tx_data_a = d; tx_cs_a = cs; tx_valid_a = 1'b1;
      @(negedge clk);
      while (!tx_ready_a && k < 200) begin @(negedge clk); k++; end
      if (!tx_ready_a) chk("accept_a_timeout", 0, 1);
      @(posedge clk); #1 tx_valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [15:0] d, input logic [2:0] cs);
      int k = 0;
      tx_data_b = d; tx_cs_b = cs; tx_valid_b = 1'b1;
      @(negedge clk);
      while (!tx_ready_b && k < 200) begin @(negedge clk); k++; end
      if (!tx_ready_b) chk("accept_b_timeout", 0, 1);
      @(posedge clk); #1 tx_valid_b = 1'b0;
   endtask

   task automatic wait_rx_a(input int target, input int bound);
      int k = 0;
      while (n_rx_a < target && k < bound) begin @(negedge clk); k++; end
      if (n_rx_a < target) chk("rx_a_timeout", 0, 1);
   endtask

   task automatic wait_rx_b(input int target, input int bound);
      int k = 0;
      while (n_rx_b < target && k < bound) begin @(negedge clk); k++; end
      if (n_rx_b < target) chk("rx_b_timeout", 0, 1);
   endtask

   initial begin
      int k, n0;
      logic [7:0] words [3];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'hE7;
      cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_lsb = 1'b0; cfg_div = 8'd0;
      tx_valid_a = 1'b0; tx_data_a = 8'h00; tx_cs_a = 2'd0;
      tx_valid_b = 1'b0; tx_data_b = 16'h0000; tx_cs_b = 3'd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_ready", tx_ready_a, 0);
      chk("rst_rx_valid", rx_valid_a, 0);
      chk("rst_rx_data", rx_data_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_cs_err", cs_err_a, 0);
      chk("rst_sck", sck_a, 1);
      chk("rst_csn", csn_a, 4'hF);
      chk("rst_mosi", mosi_a, 0);
      rst_n = 1'b1;

      // Mode 3, MSB first, div 0, loopback
      set_cfg(1'b1, 1'b1, 1'b0, 8'd0);
      n0 = n_rx_a; cserr_cnt_a = 0;
      send_a(8'hA5, 2'd0);
      wait_rx_a(n0 + 1, 500);
      chk("m3_csn", mid_csn_a, 4'b1110);
      chk("m3_edges", tog_a, 16);
      chk("m3_sck_cycles", rise_a, 8);
      chk("m3_no_cs_err", cserr_cnt_a, 0);

      // Mode 0, LSB first, div 3, target returns C3
      set_cfg(1'b0, 1'b0, 1'b1, 8'd3);
      tgt_word = 8'hC3; use_tgt = 1'b1;
      n0 = n_rx_a;
      send_a(8'h3C, 2'd2);
      wait_rx_a(n0 + 1, 500);
      use_tgt = 1'b0;
      chk("m0_mosi_bits", cap_a, 8'h3C);
      chk("m0_csn", mid_csn_a, 4'b1011);
      chk("m0_sck_period", per_a, 8);
      chk("m0_sck_cycles", rise_a, 8);

      // Out-of-range chip select on the 5-CS instance
      set_cfg(1'b1, 1'b1, 1'b0, 8'd0);
      cserr_cnt_b = 0; csn_low_b = 1'b0; n0 = n_rx_b;
      send_b(16'h1234, 3'd5);
      wait_rx_b(n0 + 1, 500);
      chk("cserr_pulse", cserr_cnt_b, 1);
      chk("cserr_csn_idle", csn_low_b, 0);

      // Reset mid-transfer
      set_cfg(1'b1, 1'b1, 1'b0, 8'd3);
      send_a(8'h96, 2'd1);
      k = 0;
      while (tog_a < 5 && k < 500) begin @(negedge clk); k++; end
      chk("rst_mid_reached_edge5", tog_a, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_csn", csn_a, 4'hF);
      chk("rst_mid_sck", sck_a, 1);
      chk("rst_mid_busy", busy_a, 0);
      exp_q_a.delete(); t_q_a.delete(); lat_q_a.delete();
      n0 = n_rx_a;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("rst_mid_no_rx", n_rx_a, n0);
      send_a(8'h5A, 2'd3);
      wait_rx_a(n0 + 1, 500);
      chk("post_rst_csn", mid_csn_a, 4'b0111);

      // 16-bit, div 255, cpol flipped mid-transfer
      set_cfg(1'b0, 1'b0, 1'b0, 8'd255);
      n0 = n_rx_b;
      send_b(16'hBEEF, 3'd0);
      repeat (1000) @(posedge clk);
      #1 cfg_cpol = 1'b1;
      wait_rx_b(n0 + 1, 10000);
      chk("w16_edges", tog_b, 32);
      chk("w16_sck_period", per_b, 512);
      chk("w16_old_cpol_hold", sck_at_rx_b, 0);
      k = 0;
      while (busy_b && k < 2000) begin @(negedge clk); k++; end
      chk("w16_done", busy_b, 0);
      repeat (3) @(negedge clk);
      chk("w16_new_cpol_idle", sck_b, 1);

      // tx_valid held for three words
      set_cfg(1'b0, 1'b1, 1'b0, 8'd1);
      n0 = n_rx_a; k = acc_a;
      tx_cs_a = 2'd0; tx_data_a = words[0]; tx_valid_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         int w = 0;
         @(negedge clk);
         while (!tx_ready_a && w < 200) begin @(negedge clk); w++; end
         @(posedge clk);
         #1;
         if (i < 2) tx_data_a = words[i + 1];
      end
      tx_valid_a = 1'b0;
      wait_rx_a(n0 + 3, 500);
      chk("stream_accepts", acc_a - k, 3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
